// File: rtl/lsu.sv
// lsu: load/store unit with a single outstanding data-memory access, byte-lane steering and a bus timeout.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them down.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        ld_i,
  input  logic        st_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        gprs_wena_i,
  input  logic [4:0]  gprs_waddr_i,
  input  logic [31:0] gprs_wdata_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        gprs_wena_o,
  output logic [4:0]  gprs_waddr_o,
  output logic [31:0] gprs_wdata_o,
  output logic        err_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_ld_q, is_ld_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lane_q, lane_d;
  logic [4:0]    rd_q, rd_d;

  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [3:0]    dmem_wstrb_q, dmem_wstrb_d;
  logic [31:0]   dmem_wdata_q, dmem_wdata_d;
  logic          gprs_wena_q, gprs_wena_d;
  logic [4:0]    gprs_waddr_q, gprs_waddr_d;
  logic [31:0]   gprs_wdata_q, gprs_wdata_d;
  logic          err_q, err_d;

  logic          access;
  logic          trap;
  logic          accept;
  logic [1:0]    lane;
  logic [3:0]    strb;
  logic [31:0]   st_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

  assign access = valid_i & (ld_i | st_i);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (size_i == 2'b01) ? addr_i[0] : (size_i[1] & (addr_i[1:0] != 2'b00));
  assign trap       = (state_q == IDLE) & access & misaligned;
`else
  assign trap       = 1'b0;
`endif

  assign accept  = (state_q == IDLE) & access & ~trap;
  assign stall_o = accept | (state_q == BUSY);

  // Lane is the access offset after aligning down to the access size.
  always_comb begin
    lane    = addr_i[1:0];
    strb    = 4'b1111;
    st_data = wdata_i;
    case (size_i)
      2'b00: begin
        strb    = 4'b0001 << lane;
        st_data = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        lane[0] = 1'b0;
        strb    = 4'b0011 << lane;
        st_data = {2{wdata_i[15:0]}};
      end
      default: lane = 2'b00;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_ld_d      = is_ld_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wstrb_d = dmem_wstrb_q;
    dmem_wdata_d = dmem_wdata_q;
    gprs_wena_d  = 1'b0;
    gprs_waddr_d = gprs_waddr_q;
    gprs_wdata_d = gprs_wdata_q;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d      = BUSY;
          is_ld_d      = ld_i;
          size_d       = size_i;
          uns_d        = unsigned_i;
          lane_d       = lane;
          rd_d         = gprs_waddr_i;
          dmem_req_d   = 1'b1;
          dmem_we_d    = ~ld_i;
          dmem_addr_d  = {addr_i[31:2], 2'b00};
          dmem_wstrb_d = ld_i ? 4'b0000 : strb;
          dmem_wdata_d = ld_i ? 32'h0 : st_data;
        end else if (trap) begin
          err_d = 1'b1;
        end else if (valid_i) begin
          gprs_wena_d  = gprs_wena_i & (gprs_waddr_i != 5'd0);
          gprs_waddr_d = gprs_waddr_i;
          gprs_wdata_d = gprs_wdata_i;
        end
      end
      BUSY: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (dmem_ack || (cnt_q == CNT_LAST)) begin
          state_d      = IDLE;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = 32'h0;
          dmem_wstrb_d = 4'b0000;
          dmem_wdata_d = 32'h0;
          if (dmem_ack) begin
            if (is_ld_q) begin
              gprs_wena_d  = (rd_q != 5'd0);
              gprs_waddr_d = rd_q;
              gprs_wdata_d = ld_data;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_ld_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      rd_q         <= 5'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wstrb_q <= 4'b0000;
      dmem_wdata_q <= 32'h0;
      gprs_wena_q  <= 1'b0;
      gprs_waddr_q <= 5'd0;
      gprs_wdata_q <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_ld_q      <= is_ld_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      rd_q         <= rd_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      dmem_wdata_q <= dmem_wdata_d;
      gprs_wena_q  <= gprs_wena_d;
      gprs_waddr_q <= gprs_waddr_d;
      gprs_wdata_q <= gprs_wdata_d;
      err_q        <= err_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wstrb   = dmem_wstrb_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign gprs_wena_o  = gprs_wena_q;
  assign gprs_waddr_o = gprs_waddr_q;
  assign gprs_wdata_o = gprs_wdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized bench for lsu; each operation is planned into a per-cycle expectation timeline
// derived from the access rules, and one negedge process compares the DUT against it.
`timescale 1ns/1ps
module tb_lsu;
  localparam int TMO  = 4;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0, ld_i = 1'b0, st_i = 1'b0, unsigned_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0, gprs_wdata_i = 32'h0;
  logic        gprs_wena_i = 1'b0;
  logic [4:0]  gprs_waddr_i = 5'd0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_req, dmem_we, stall_o, gprs_wena_o, err_o;
  logic [31:0] dmem_addr, dmem_wdata, gprs_wdata_o;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  gprs_waddr_o;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ld_i(ld_i), .st_i(st_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gprs_wena_i(gprs_wena_i), .gprs_waddr_i(gprs_waddr_i), .gprs_wdata_i(gprs_wdata_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_o(stall_o),
    .gprs_wena_o(gprs_wena_o), .gprs_waddr_o(gprs_waddr_o), .gprs_wdata_o(gprs_wdata_o),
    .err_o(err_o)
  );

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] bwd;
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wd;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        wdOn;
    logic [31:0] wd;
    logic        addrOn;
    logic [31:0] addr;
    logic        busOn;
    logic [3:0]  strb;
    logic [31:0] bwd;
    logic        errOn;
  } pin_t;

  exp_t expTab [MAXC];
  pin_t pinTab [MAXC];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   checkOn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference rules: alignment, lane strobes, lane replication and load extension.
  function automatic logic [31:0] effAddr(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd1) return a - (a % 2);
    if (sz == 2'd2) return a - (a % 4);
    return a;
  endfunction

  function automatic bit isMisaligned(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] modelStrb(logic [1:0] sz, logic [31:0] ea);
    if (sz == 2'd0) return 4'(1 << (ea % 4));
    if (sz == 2'd1) return 4'(3 << (ea % 4));
    return 4'd15;
  endfunction

  function automatic logic [31:0] modelWdata(logic [1:0] sz, logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] modelLoad(logic [1:0] sz, bit uns, logic [31:0] ea, logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (ea % 4));
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    pin_t p;
    if (cyc >= MAXC) return;
    e = expTab[cyc];
    p = pinTab[cyc];
    cmp("stall", 32'(stall_o), 32'(e.stall));
    cmp("req", 32'(dmem_req), 32'(e.req));
    cmp("wena", 32'(gprs_wena_o), 32'(e.wena));
    cmp("err", 32'(err_o), 32'(e.err));
    if (e.req) begin
      cmp("we", 32'(dmem_we), 32'(e.we));
      cmp("addr", dmem_addr, e.addr);
      if (e.we) begin
        cmp("wstrb", 32'(dmem_wstrb), 32'(e.strb));
        cmp("wdata", dmem_wdata, e.bwd);
      end
    end
    if (e.wena) begin
      cmp("waddr", 32'(gprs_waddr_o), 32'(e.waddr));
      cmp("wbdata", gprs_wdata_o, e.wd);
    end
    if (p.wdOn) begin
      cmp("pin_wena", 32'(gprs_wena_o), 32'd1);
      cmp("pin_wbdata", gprs_wdata_o, p.wd);
    end
    if (p.addrOn) cmp("pin_addr", dmem_addr, p.addr);
    if (p.busOn) begin
      cmp("pin_we", 32'(dmem_we), 32'd1);
      cmp("pin_wstrb", 32'(dmem_wstrb), 32'(p.strb));
      cmp("pin_wdata", dmem_wdata, p.bwd);
    end
    if (p.errOn) cmp("pin_err", 32'(err_o), 32'd1);
  endtask

  always @(negedge clk) if (checkOn) checkOutput();

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic junkInputs();
    valid_i      = 1'($urandom);
    ld_i         = 1'($urandom);
    st_i         = 1'($urandom);
    size_i       = 2'($urandom);
    unsigned_i   = 1'($urandom);
    addr_i       = $urandom;
    wdata_i      = $urandom;
    gprs_wena_i  = 1'($urandom);
    gprs_waddr_i = 5'($urandom);
    gprs_wdata_i = $urandom;
  endtask

  task automatic doIdle();
    junkInputs();
    valid_i    = 1'b0;
    dmem_ack   = 1'($urandom);
    dmem_rdata = $urandom;
    nextCycle();
  endtask

  task automatic doAlu(input bit wen, input logic [4:0] rd, input logic [31:0] d);
    int t;
    t = cyc;
    junkInputs();
    valid_i = 1'b1; ld_i = 1'b0; st_i = 1'b0;
    gprs_wena_i = wen; gprs_waddr_i = rd; gprs_wdata_i = d;
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    expTab[t+1].wena  = wen && (rd != 5'd0);
    expTab[t+1].waddr = rd;
    expTab[t+1].wd    = d;
    nextCycle();
  endtask

  task automatic doAccess(input bit isLd, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input int ackAt,
                          input logic [31:0] rdata);
    int t, m;
    logic [31:0] ea;
    t = cyc;
    valid_i = 1'b1; ld_i = isLd; st_i = !isLd; size_i = sz; unsigned_i = uns;
    addr_i = a; wdata_i = d; gprs_wena_i = 1'($urandom); gprs_waddr_i = rd;
    gprs_wdata_i = $urandom; dmem_ack = 1'b0; dmem_rdata = $urandom;
    ea = effAddr(sz, a);
`ifdef LSU_MISALIGN_TRAP_EN
    if (isMisaligned(sz, a)) begin
      expTab[t+1].err = 1'b1;
      nextCycle();
      return;
    end
`endif
    expTab[t].stall = 1'b1;
    m = (ackAt <= TMO) ? ackAt : TMO;
    for (int i = 1; i <= m; i++) begin
      expTab[t+i].stall = 1'b1;
      expTab[t+i].req   = 1'b1;
      expTab[t+i].we    = !isLd;
      expTab[t+i].addr  = ea - (ea % 4);
      expTab[t+i].strb  = modelStrb(sz, ea);
      expTab[t+i].bwd   = modelWdata(sz, d);
    end
    if (ackAt <= TMO) begin
      expTab[t+ackAt+1].wena  = isLd && (rd != 5'd0);
      expTab[t+ackAt+1].waddr = rd;
      expTab[t+ackAt+1].wd    = modelLoad(sz, uns, ea, rdata);
    end else begin
      expTab[t+TMO+1].err = 1'b1;
    end
    nextCycle();
    for (int i = 1; i <= m; i++) begin
      junkInputs();
      dmem_ack   = (i == ackAt);
      dmem_rdata = (i == ackAt) ? rdata : $urandom;
      nextCycle();
    end
  endtask

  task automatic doResetMid();
    int t;
    t = cyc;
    junkInputs();
    valid_i = 1'b1; ld_i = 1'b1; st_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_0400;
    gprs_waddr_i = 5'd9; dmem_ack = 1'b0;
    expTab[t].stall = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      expTab[t+i].stall = 1'b1;
      expTab[t+i].req   = 1'b1;
      expTab[t+i].we    = 1'b0;
      expTab[t+i].addr  = 32'h0000_0400;
    end
    nextCycle();
    junkInputs();
    dmem_ack = 1'b0;
    nextCycle();
    junkInputs();
    dmem_ack = 1'b0;
    rst = 1'b0;
    nextCycle();
    rst = 1'b1;
  endtask

  task automatic applyStimulus();
    int k, ackAt;
    logic [1:0] sz;
    logic [4:0] rd;
    k     = $urandom_range(0, 24);
    ackAt = $urandom_range(1, 6);
    sz    = 2'($urandom_range(0, 2));
    rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    if (k < 4) doIdle();
    else if (k < 10) doAlu(1'($urandom), rd, $urandom);
    else if (k < 24) doAccess(1'($urandom), sz, 1'($urandom), $urandom, $urandom, rd, ackAt, $urandom);
    else doResetMid();
  endtask

  initial begin
    int t;
    for (int i = 0; i < MAXC; i++) begin
      expTab[i] = '0;
      pinTab[i] = '0;
    end
    nextCycle();
    checkOn = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b1;

    doAlu(1'b1, 5'd3, 32'h0000_1234);
    doAlu(1'b1, 5'd0, 32'hFFFF_FFFF);

    t = cyc;
    for (int i = 1; i <= 3; i++) begin
      pinTab[t+i].addrOn = 1'b1;
      pinTab[t+i].addr   = 32'h0000_0100;
    end
    pinTab[t+4].wdOn = 1'b1; pinTab[t+4].wd = 32'hDEAD_BEEF;
    doAccess(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd5, 3, 32'hDEAD_BEEF);

    t = cyc;
    pinTab[t+2].wdOn = 1'b1; pinTab[t+2].wd = 32'hFFFF_FF80;
    doAccess(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 5'd6, 1, 32'h8011_2233);
    t = cyc;
    pinTab[t+2].wdOn = 1'b1; pinTab[t+2].wd = 32'h0000_0080;
    doAccess(1'b1, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 5'd6, 1, 32'h8011_2233);
    t = cyc;
    pinTab[t+2].wdOn = 1'b1; pinTab[t+2].wd = 32'hFFFF_8011;
    doAccess(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 5'd7, 1, 32'h8011_2233);

    t = cyc;
    pinTab[t+1].busOn = 1'b1; pinTab[t+1].strb = 4'b1100; pinTab[t+1].bwd = 32'hABCD_ABCD;
    pinTab[t+1].addrOn = 1'b1; pinTab[t+1].addr = 32'h0000_0200;
    doAccess(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd4, 2, 32'h0);

    t = cyc;
    pinTab[t+TMO+1].errOn = 1'b1;
    doAccess(1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 5'd9, 99, 32'h0);
    doIdle();

    t = cyc;
`ifdef LSU_MISALIGN_TRAP_EN
    pinTab[t+1].errOn = 1'b1;
`else
    pinTab[t+1].addrOn = 1'b1; pinTab[t+1].addr = 32'h0000_0100;
    pinTab[t+2].wdOn = 1'b1; pinTab[t+2].wd = 32'h1122_3344;
`endif
    doAccess(1'b1, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 5'd8, 1, 32'h1122_3344);

    doResetMid();
    t = cyc;
    pinTab[t+1].wdOn = 1'b1; pinTab[t+1].wd = 32'h1234_5678;
    doAlu(1'b1, 5'd7, 32'h1234_5678);

    for (int n = 0; n < 250; n++) applyStimulus();
    repeat (3) doIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles dmem_req is held without dmem_ack before the access is aborted.
REQ-002 SHALL have ports in this order:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- valid_i  in  1  execute-stage result valid this cycle.
- ld_i  in  1  instruction is a load.
- st_i  in  1  instruction is a store.
- size_i  in  2  access size: 00 byte, 01 half, 10 word.
- unsigned_i  in  1  zero-extend load (LBU/LHU).
- addr_i  in  32  effective byte address.
- wdata_i  in  32  store data in low bits.
- gprs_wena_i  in  1  execute-stage register write request.
- gprs_waddr_i  in  5  destination register.
- gprs_wdata_i  in  32  ALU result for non-memory instructions.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  32  word address, bits [1:0] always 0.
- dmem_wstrb  out  4  byte write enables.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_ack  in  1  request completed this cycle.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- stall_o  out  1  hold upstream stages.
- gprs_wena_o  out  1  register-file write enable.
- gprs_waddr_o  out  5  register-file write address.
- gprs_wdata_o  out  32  register-file write data.
- err_o  out  1  one-cycle pulse: bus timeout or trapped misaligned access.

Function
REQ-003 SHALL implement states IDLE and BUSY; reset state IDLE.
REQ-004 In IDLE with valid_i=1 and ld_i=st_i=0, SHALL register gprs_wena_i/waddr/wdata to the gprs_* outputs one cycle later; stall_o stays 0.
REQ-005 In IDLE with valid_i=1 and ld_i or st_i=1 (accepted access), SHALL assert stall_o combinationally that cycle, latch the request and enter BUSY at the next edge.
REQ-006 In BUSY SHALL drive dmem_req=1 with stable dmem_we/addr/wstrb/wdata and stall_o=1 until the dmem_ack cycle inclusive; ack in the first BUSY cycle is legal.
REQ-007 Store strobes SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word); dmem_wdata SHALL replicate the byte/half across all lanes; little-endian.
REQ-008 On ack of a load SHALL, at the next edge, write the selected byte (addr[1:0]) or half (addr[1]) sign- or zero-extended per unsigned_i, or the whole word, to gprs_waddr; return to IDLE.
REQ-009 On ack of a store SHALL produce gprs_wena_o=0 and return to IDLE.
REQ-010 gprs_wena_o SHALL be forced 0 whenever the destination register is 0.
REQ-011 A counter SHALL count BUSY cycles without ack; on reaching TIMEOUT_CYCLES SHALL drop dmem_req, pulse err_o, suppress writeback, return to IDLE; ack in the same cycle wins over timeout.
REQ-012 dmem_ack while IDLE SHALL be ignored; valid_i while BUSY SHALL be ignored (upstream is held by stall_o).
REQ-013 When not writing back, gprs_wena_o SHALL be 0 each cycle (single-cycle write pulses).

Reset
REQ-014 While rst=0 at an edge SHALL go to IDLE, clear counter, and drive every registered output (gprs_*, err_o, dmem_*) to 0.
REQ-015 Reset during BUSY SHALL drop dmem_req at that edge and discard the pending access with no writeback.

Configuration
REQ-016 With LSU_MISALIGN_TRAP_EN defined, an access with half and addr[0]=1 or word and addr[1:0]!=0 SHALL issue no dmem_req, pulse err_o next cycle, suppress writeback, and not stall.
REQ-017 Without LSU_MISALIGN_TRAP_EN, misaligned addresses SHALL be aligned down (half: addr[0] cleared; word: addr[1:0] cleared) and executed normally; err_o only for timeout.

Verification
REQ-018 Load word addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF, rd=5 -> stall 4 cycles, dmem_addr 0x100, x5=0xDEADBEEF one cycle after ack.
REQ-019 LB addr 0x103, rdata 0x80112233 -> x=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
REQ-020 SH addr 0x202 data 0x0000ABCD -> wstrb 1100, dmem_wdata 0xABCDABCD, dmem_we=1, no writeback.
REQ-021 Load with no ack, TIMEOUT_CYCLES=4 -> dmem_req high exactly 4 cycles, err_o one pulse, no writeback, stall_o released.
REQ-022 LW addr 0x101 -> with macro: no dmem_req, err_o pulse; without: dmem_addr 0x100, normal completion.
REQ-023 rst=0 asserted in second BUSY cycle -> dmem_req 0 after that edge, no writeback, subsequent ALU op writes normally.
